// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    // Width of a counter that must hold 0..max_out inclusive.
    function automatic int cnt_w(input int max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

    // Width of the watchdog timer; at least one bit even when disabled.
    function automatic int tmr_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

    // Width of a master index; at least one bit for a single master.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority picker: the requester closest after
// i_last (cyclically) wins. Shared with the slave-side arbiters.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int NUMM = 2,
    localparam int IW   = idx_w(NUMM)
) (
    input  logic [NUMM-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NUMM-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    int w_dist;
    int w_best;
    int w_best_dist;

    // Pick the requester with the smallest cyclic distance past i_last.
    always_comb begin
        w_dist      = 0;
        w_best      = 0;
        w_best_dist = NUMM;
        o_valid     = |i_req;
        for (int i = 0; i < NUMM; i++) begin
            if (i_req[i]) begin
                w_dist = i - int'(i_last) - 1;
                if (w_dist < 0) w_dist = w_dist + NUMM;
                if (w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    w_best      = i;
                end
            end
        end
        for (int i = 0; i < NUMM; i++) begin
            o_gnt[i] = o_valid && (i == w_best);
        end
        o_idx = IW'(w_best);
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B4 pipelined arbiter: holds the grant for a whole
// cyc burst, counts outstanding requests so responses route to the owner,
// and synthesizes err when a slave goes silent for TIMEOUT cycles.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter  int NUMM    = 2,
    parameter  int MAX_OUT = 4,
    parameter  int TIMEOUT = 255,
    localparam int CNTW    = cnt_w(MAX_OUT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NUMM-1:0] m_cyc,
    input  logic [NUMM-1:0] m_stb,
    output logic [NUMM-1:0] m_stall,
    output logic [NUMM-1:0] m_ack,
    output logic [NUMM-1:0] m_err,
    input  logic            bus_stall,
    input  logic            bus_ack,
    input  logic            bus_err,
    output logic            bus_cyc,
    output logic            bus_stb,
    output logic [NUMM-1:0] gnt,
    output logic [CNTW-1:0] outstanding,
    output logic            timeout
);

    localparam int IW = idx_w(NUMM);
    localparam int TW = tmr_w(TIMEOUT);

    arb_state_e      r_state, w_state_nx;
    logic [NUMM-1:0] r_gnt, w_gnt_nx;
    logic [IW-1:0]   r_gidx, w_gidx_nx;
    logic [IW-1:0]   r_last, w_last_nx;
    logic [CNTW-1:0] r_out, w_out_nx;
    logic [TW-1:0]   r_tmr, w_tmr_nx;

    logic [NUMM-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_vld;
    logic            w_nz, w_full, w_resp, w_fire, w_accept;

    wb_rr_pick #(.NUMM(NUMM)) u_pick (
        .i_req   (m_cyc),
        .i_last  (r_last),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    assign w_nz   = (r_out != '0);
    assign w_full = (r_out == CNTW'(MAX_OUT));
    // Responses with nothing in flight are stale and never counted.
    assign w_resp = (bus_ack | bus_err) & w_nz;
    // A real response in the deadline cycle beats the watchdog.
    assign w_fire = (TIMEOUT != 0) && (r_tmr == TW'(TIMEOUT)) && w_nz && !w_resp;

    assign gnt         = r_gnt;
    assign outstanding = r_out;
    assign timeout     = w_fire;

    // Bus handshakes, counter/timer update and next-state selection.
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_gidx_nx  = r_gidx;
        w_last_nx  = r_last;
        m_stall    = '1;
        m_ack      = '0;
        m_err      = '0;
        bus_cyc    = 1'b0;
        bus_stb    = 1'b0;

        case (r_state)
            ARB_GRANT: begin
                bus_cyc         = m_cyc[r_gidx];
                bus_stb         = m_stb[r_gidx] & ~w_full;
                m_stall[r_gidx] = bus_stall | w_full;
            end
            ARB_DRAIN: bus_cyc = 1'b1;
            default: ;
        endcase

        if (r_state != ARB_IDLE) begin
            m_ack[r_gidx] = bus_ack & w_nz;
            m_err[r_gidx] = (bus_err & w_nz) | w_fire;
        end

        w_accept = bus_stb & ~bus_stall;
        if (w_fire) w_out_nx = '0;
        else        w_out_nx = r_out + CNTW'(w_accept) - CNTW'(w_resp);

        if ((TIMEOUT == 0) || !w_nz || w_resp || w_fire) w_tmr_nx = '0;
        else                                             w_tmr_nx = r_tmr + TW'(1);

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nx = ARB_GRANT;
                    w_gnt_nx   = w_pick_gnt;
                    w_gidx_nx  = w_pick_idx;
                    w_last_nx  = w_pick_idx;
                end
            end
            ARB_GRANT: begin
                // Owner released cyc: hand back only once nothing is in flight.
                if (!m_cyc[r_gidx]) begin
                    if (w_out_nx == '0) begin
                        w_state_nx = ARB_IDLE;
                        w_gnt_nx   = '0;
                    end else begin
                        w_state_nx = ARB_DRAIN;
                    end
                end
            end
            ARB_DRAIN: begin
                if (w_out_nx == '0) begin
                    w_state_nx = ARB_IDLE;
                    w_gnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = ARB_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    // State, grant, round-robin pointer, outstanding counter and watchdog timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_last  <= IW'(NUMM - 1);
            r_out   <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_gidx  <= w_gidx_nx;
            r_last  <= w_last_nx;
            r_out   <= w_out_nx;
            r_tmr   <= w_tmr_nx;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: directed vector table, hand-written timeout and
// reset sequences, then random traffic against a cycle-level reference model.
module tb_wb_arbiter_rr;

    localparam int NM = 2;
    localparam int MO = 4;
    localparam int TO = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] m_cyc, m_stb, m_stall, m_ack, m_err, gnt;
    logic          bus_stall, bus_ack, bus_err, bus_cyc, bus_stb, timeout;
    logic [CW-1:0] outstanding;

    always #5 clk = ~clk;

    wb_arbiter_rr #(.NUMM(NM), .MAX_OUT(MO), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_cyc       (m_cyc),
        .m_stb       (m_stb),
        .m_stall     (m_stall),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .bus_stall   (bus_stall),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .bus_cyc     (bus_cyc),
        .bus_stb     (bus_stb),
        .gnt         (gnt),
        .outstanding (outstanding),
        .timeout     (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = nobody), draining flag,
    // last winner, requests in flight, cycles waiting for a response.
    int mg, mlast, mcnt, mtmr;
    bit mdrain;

    logic [NM-1:0] s_stall, s_ack, s_err, s_gnt;
    logic          s_bcyc, s_bstb, s_to;
    logic [CW-1:0] s_out;

    typedef struct {
        logic [NM-1:0] cyc;
        logic [NM-1:0] stb;
        logic          ack;
        logic [NM-1:0] gnt;
        int            out;
        logic [NM-1:0] stall;
        logic          bstb;
        logic [NM-1:0] mack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [NM-1:0] cyc, stb, input logic ack,
                               input logic [NM-1:0] g, input int o,
                               input logic [NM-1:0] st, input logic bs,
                               input logic [NM-1:0] ma);
        vec_t r;
        r.cyc = cyc; r.stb = stb; r.ack = ack; r.gnt = g; r.out = o;
        r.stall = st; r.bstb = bs; r.mack = ma;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic mreset();
        mg = -1; mdrain = 0; mlast = NM - 1; mcnt = 0; mtmr = 0;
    endtask

    // One bus cycle: drive inputs, sample and check at negedge, advance model.
    task automatic step(input logic [NM-1:0] cyc, stb, input logic bst, ack, err);
        logic [NM-1:0] e_stall, e_ack, e_err, e_gnt;
        logic          e_bcyc, e_bstb, fire, resp, acc;
        int            ncnt;
        m_cyc = cyc; m_stb = stb; bus_stall = bst; bus_ack = ack; bus_err = err;
        @(negedge clk);
        s_stall = m_stall; s_ack = m_ack; s_err = m_err; s_gnt = gnt;
        s_bcyc = bus_cyc; s_bstb = bus_stb; s_to = timeout; s_out = outstanding;

        e_stall = '1; e_ack = '0; e_err = '0; e_gnt = '0; e_bcyc = 0; e_bstb = 0;
        resp = (ack || err) && (mcnt != 0);
        fire = (mtmr == TO) && (mcnt != 0) && !(ack || err);
        if (mg >= 0) begin
            e_gnt[mg] = 1'b1;
            e_ack[mg] = ack && (mcnt != 0);
            e_err[mg] = (err && (mcnt != 0)) || fire;
            if (mdrain) e_bcyc = 1'b1;
            else begin
                e_bcyc      = cyc[mg];
                e_bstb      = stb[mg] && (mcnt < MO);
                e_stall[mg] = bst || (mcnt == MO);
            end
        end
        acc = e_bstb && !bst;

        chk("gnt", s_gnt, e_gnt);
        chk("outstanding", s_out, mcnt);
        chk("m_stall", s_stall, e_stall);
        chk("m_ack", s_ack, e_ack);
        chk("m_err", s_err, e_err);
        chk("bus_cyc", s_bcyc, e_bcyc);
        chk("bus_stb", s_bstb, e_bstb);
        chk("timeout", s_to, fire);

        ncnt = fire ? 0 : mcnt + int'(acc) - int'(resp);
        mtmr = (mcnt == 0 || resp || fire) ? 0 : mtmr + 1;
        if (mg < 0) begin
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (mlast + k) % NM;
                if (cyc[c]) begin
                    mg = c; mlast = c;
                    break;
                end
            end
        end else if (!mdrain) begin
            if (!cyc[mg]) begin
                if (ncnt == 0) mg = -1;
                else           mdrain = 1;
            end
        end else if (ncnt == 0) begin
            mg = -1; mdrain = 0;
        end
        mcnt = ncnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NM-1:0] rc, rs;
        rst = 1'b1; m_cyc = '0; m_stb = '0; bus_stall = 0; bus_ack = 0; bus_err = 0;
        mreset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_stall", m_stall, 2'b11);
        chk("rst_bus_cyc", bus_cyc, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;

        //          cyc    stb    ack   gnt  out stall bstb mack
        tbl.push_back(v(2'b11, 2'b00, 0, 2'b00, 0, 2'b11, 0, 2'b00)); // both request
        tbl.push_back(v(2'b11, 2'b00, 0, 2'b01, 0, 2'b10, 0, 2'b00)); // m0 first
        tbl.push_back(v(2'b10, 2'b00, 0, 2'b01, 0, 2'b10, 0, 2'b00)); // m0 drops
        tbl.push_back(v(2'b10, 2'b00, 0, 2'b00, 0, 2'b11, 0, 2'b00)); // idle bubble
        tbl.push_back(v(2'b10, 2'b00, 0, 2'b10, 0, 2'b01, 0, 2'b00)); // m1 granted
        tbl.push_back(v(2'b00, 2'b00, 0, 2'b10, 0, 2'b01, 0, 2'b00));
        tbl.push_back(v(2'b11, 2'b00, 0, 2'b00, 0, 2'b11, 0, 2'b00));
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 0, 2'b10, 1, 2'b00)); // back to m0, req 1
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 1, 2'b10, 1, 2'b00));
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 2, 2'b10, 1, 2'b00));
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 3, 2'b10, 1, 2'b00)); // req 4
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 4, 2'b11, 0, 2'b00)); // full
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 4, 2'b11, 0, 2'b00));
        tbl.push_back(v(2'b11, 2'b01, 1, 2'b01, 4, 2'b11, 0, 2'b01)); // ack frees a slot
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 3, 2'b10, 1, 2'b00)); // req 5 accepted
        tbl.push_back(v(2'b11, 2'b01, 1, 2'b01, 4, 2'b11, 0, 2'b01));
        tbl.push_back(v(2'b11, 2'b01, 1, 2'b01, 3, 2'b10, 1, 2'b01)); // req 6 + ack
        tbl.push_back(v(2'b11, 2'b00, 1, 2'b01, 3, 2'b10, 0, 2'b01));
        tbl.push_back(v(2'b11, 2'b01, 1, 2'b01, 2, 2'b10, 1, 2'b01)); // accept+ack at 2
        tbl.push_back(v(2'b11, 2'b00, 1, 2'b01, 2, 2'b10, 0, 2'b01));
        tbl.push_back(v(2'b11, 2'b00, 1, 2'b01, 1, 2'b10, 0, 2'b01));
        tbl.push_back(v(2'b11, 2'b00, 1, 2'b01, 0, 2'b10, 0, 2'b00)); // stray ack dropped
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 0, 2'b10, 1, 2'b00));
        tbl.push_back(v(2'b11, 2'b01, 0, 2'b01, 1, 2'b10, 1, 2'b00));
        tbl.push_back(v(2'b10, 2'b00, 0, 2'b01, 2, 2'b10, 0, 2'b00)); // drop cyc with 2
        tbl.push_back(v(2'b10, 2'b00, 0, 2'b01, 2, 2'b11, 0, 2'b00)); // draining
        tbl.push_back(v(2'b10, 2'b00, 1, 2'b01, 2, 2'b11, 0, 2'b01));
        tbl.push_back(v(2'b10, 2'b00, 1, 2'b01, 1, 2'b11, 0, 2'b01));
        tbl.push_back(v(2'b10, 2'b00, 0, 2'b00, 0, 2'b11, 0, 2'b00)); // idle
        tbl.push_back(v(2'b00, 2'b00, 0, 2'b10, 0, 2'b01, 0, 2'b00)); // m1 granted
        tbl.push_back(v(2'b00, 2'b00, 0, 2'b00, 0, 2'b11, 0, 2'b00));

        foreach (tbl[i]) begin
            step(tbl[i].cyc, tbl[i].stb, 1'b0, tbl[i].ack, 1'b0);
            chk($sformatf("tbl%0d_gnt", i), s_gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_out", i), s_out, tbl[i].out);
            chk($sformatf("tbl%0d_stall", i), s_stall, tbl[i].stall);
            chk($sformatf("tbl%0d_bstb", i), s_bstb, tbl[i].bstb);
            chk($sformatf("tbl%0d_ack", i), s_ack, tbl[i].mack);
        end

        // Watchdog: one request, silent slave, fire 8 cycles later.
        step(2'b01, 2'b00, 0, 0, 0);
        step(2'b01, 2'b01, 0, 0, 0);
        for (int i = 1; i <= TO; i++) begin
            step(2'b01, 2'b00, 0, 0, 0);
            chk("wd_quiet", s_to, 0);
            chk("wd_out_held", s_out, 1);
        end
        step(2'b01, 2'b00, 0, 0, 0);
        chk("wd_pulse", s_to, 1);
        chk("wd_err", s_err, 2'b01);
        step(2'b01, 2'b00, 0, 1, 0);
        chk("wd_late_ack", s_ack, 2'b00);
        chk("wd_out_zero", s_out, 0);
        chk("wd_no_pulse", s_to, 0);
        step(2'b00, 2'b00, 0, 0, 0);
        step(2'b00, 2'b00, 0, 0, 0);

        // Asynchronous reset in GRANT with 3 outstanding.
        step(2'b01, 2'b00, 0, 0, 0);
        repeat (3) step(2'b01, 2'b01, 0, 0, 0);
        chk("pre_rst_out", outstanding, 3);
        m_cyc = 2'b11; m_stb = 2'b00;
        rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_out", outstanding, 0);
        chk("arst_stall", m_stall, 2'b11);
        chk("arst_bus_cyc", bus_cyc, 0);
        mreset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2'b11, 2'b00, 0, 1, 0);
        chk("post_rst_ack_dropped", s_ack, 2'b00);
        step(2'b11, 2'b00, 0, 0, 0);
        chk("post_rst_m0_first", s_gnt, 2'b01);

        // Random traffic against the model.
        rc = 2'b11;
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(7) == 0) rc[m] = ~rc[m];
                rs[m] = rc[m] & ($urandom_range(1) == 1);
            end
            step(rc, rs, $urandom_range(3) == 0, $urandom_range(9) < 4,
                 $urandom_range(39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
